// File: rtl/csa_accum_resolver.sv
// csa_accum_resolver: carry-save multi-operand accumulator with a chunked
// multi-cycle carry-propagate resolve stage and a valid/ready result port.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   clr             synchronous clear/abort
//   in_vld/in_rdy   operand handshake; in_dat operand, in_last ends the set
//   out_vld/out_rdy result handshake; out_sum result mod 2^WIDTH
//   out_ovf         sticky overflow of the true set sum
module csa_accum_resolver #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             in_last,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ACC, RESOLVE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             cin_q, cin_d;
    logic             ovf_q, ovf_d;
    logic             vld_q, vld_d;

    logic             accept;
    logic             last_chunk;
    logic [WIDTH-1:0] maj;
    logic [CHUNK:0]   chunk_res;

    assign accept     = in_vld & in_rdy;
    assign last_chunk = (idx_q == IW'(NCH - 1));
    assign maj        = (s_q & c_q) | (s_q & in_dat) | (c_q & in_dat);

    // One CHUNK-wide slice of the final S + C addition, carry rippled
    // between cycles through cin_q.
    assign chunk_res = {1'b0, s_q[idx_q*CHUNK +: CHUNK]}
                     + {1'b0, c_q[idx_q*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, cin_q};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept) state_d = in_last ? RESOLVE : ACC;
                ACC:     if (accept && in_last) state_d = RESOLVE;
                RESOLVE: if (last_chunk) state_d = DONE;
                DONE:    if (out_rdy) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_rdy = (state_q == IDLE) || (state_q == ACC);
    end

    assign out_vld = vld_q;
    assign out_sum = sum_q;
    assign out_ovf = ovf_q;

    // Datapath next-state
    always_comb begin
        s_d   = s_q;
        c_d   = c_q;
        sum_d = sum_q;
        idx_d = idx_q;
        cin_d = cin_q;
        ovf_d = ovf_q;
        vld_d = vld_q;
        if (clr) begin
            // out_sum deliberately survives an abort
            s_d   = '0;
            c_d   = '0;
            idx_d = '0;
            cin_d = 1'b0;
            ovf_d = 1'b0;
            vld_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        s_d   = in_dat;
                        c_d   = '0;
                        ovf_d = 1'b0;
                    end
                end
                ACC: begin
                    if (accept) begin
                        s_d   = s_q ^ c_q ^ in_dat;
                        c_d   = {maj[WIDTH-2:0], 1'b0};
                        // bit shifted out of the carry vector is weight 2^WIDTH
                        ovf_d = ovf_q | maj[WIDTH-1];
                    end
                end
                RESOLVE: begin
                    sum_d[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                    if (last_chunk) begin
                        idx_d = '0;
                        cin_d = 1'b0;
                        ovf_d = ovf_q | chunk_res[CHUNK];
                        vld_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cin_d = chunk_res[CHUNK];
                    end
                end
                DONE: begin
                    if (out_rdy) vld_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= '0;
            c_q   <= '0;
            sum_q <= '0;
            idx_q <= '0;
            cin_q <= 1'b0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            c_q   <= c_d;
            sum_q <= sum_d;
            idx_q <= idx_d;
            cin_q <= cin_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
        end
    end

endmodule

// File: tb/tb_csa_accum_resolver.sv
// tb_csa_accum_resolver: directed self-checking bench for csa_accum_resolver
// (defaults WIDTH=32, CHUNK=8).
module tb_csa_accum_resolver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [31:0] in_dat = '0;
    logic        in_last = 1'b0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [31:0] out_sum;
    logic        out_ovf;

    int tests = 0;
    int fails = 0;

    csa_accum_resolver #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_last(in_last),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operand, accepted on the next rising edge (caller ensures in_rdy).
    task automatic send(input logic [31:0] d, input logic last);
        @(negedge clk);
        in_vld  = 1'b1;
        in_dat  = d;
        in_last = last;
        @(posedge clk);
        #1;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    // Wait (bounded) for a result, check it, then take it.
    task automatic get_result(input string tag, input logic [31:0] esum,
                              input logic eovf);
        int n = 0;
        while (!out_vld && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_vld"}, 32'(out_vld), 32'd1);
        check({tag, "_sum"}, out_sum, esum);
        check({tag, "_ovf"}, 32'(out_ovf), 32'(eovf));
        check({tag, "_rdy_done"}, 32'(in_rdy), 32'd0);
        @(negedge clk);
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        check({tag, "_vld_drop"}, 32'(out_vld), 32'd0);
        check({tag, "_idle_rdy"}, 32'(in_rdy), 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_rdy", 32'(in_rdy), 32'd1);
        check("rst_sum", out_sum, 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;

        // 1: back-to-back 5 + 7 + 10 = 0x16, exact latency of 4
        send(32'h5, 1'b0);
        send(32'h7, 1'b0);
        send(32'hA, 1'b1);
        check("t1_lat0", 32'(out_vld), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check("t1_lat", 32'(out_vld), (k == 4) ? 32'd1 : 32'd0);
        end
        get_result("t1", 32'h16, 1'b0);

        // 2: overflow through the carry vector, then through final carry-out
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h2, 1'b1);
        get_result("t2a", 32'h0, 1'b1);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h1, 1'b1);
        get_result("t2b", 32'h0, 1'b1);

        // 3: single operand; ovf from previous set must be gone
        send(32'hDEAD_BEEF, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("t3_rdy_res", 32'(in_rdy), 32'd0);
            @(posedge clk);
            #1;
        end
        get_result("t3", 32'hDEAD_BEEF, 1'b0);

        // 4: backpressure in DONE with in_vld held high
        send(32'h1234, 1'b0);
        send(32'h4321, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        in_vld  = 1'b1;
        in_dat  = 32'hAAAA;
        in_last = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("t4_vld", 32'(out_vld), 32'd1);
            check("t4_sum", out_sum, 32'h5555);
            check("t4_ovf", 32'(out_ovf), 32'd0);
            check("t4_rdy", 32'(in_rdy), 32'd0);
            @(posedge clk);
            #1;
        end
        in_vld  = 1'b0;
        in_last = 1'b0;
        get_result("t4", 32'h5555, 1'b0);
        send(32'h11, 1'b1);
        get_result("t4n", 32'h11, 1'b0);

        // 5: clr during chunk 2 of a set holding carry-in and overflow
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        clr    = 1'b1;
        in_vld = 1'b1;
        in_dat = 32'h77;
        @(posedge clk);
        #1;
        clr    = 1'b0;
        in_vld = 1'b0;
        check("t5_idle", 32'(in_rdy), 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("t5_novld", 32'(out_vld), 32'd0);
            @(posedge clk);
            #1;
        end
        send(32'h1, 1'b0);
        send(32'h2, 1'b1);
        get_result("t5", 32'h3, 1'b0);

        // 6: async reset mid-ACC, between clock edges
        send(32'h40, 1'b0);
        send(32'h50, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_sum", out_sum, 32'h0);
        check("t6_rdy", 32'(in_rdy), 32'd1);
        check("t6_vld", 32'(out_vld), 32'd0);
        check("t6_ovf", 32'(out_ovf), 32'd0);
        #1;
        rst = 1'b0;
        send(32'h7, 1'b0);
        send(32'h8, 1'b1);
        get_result("t6", 32'hF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
